// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide with a fixed 34-cycle turnaround.
// Operands are reduced to magnitudes at start; the sign is applied as the result is captured.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [10:0] control_result,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        ready,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;
    logic [5:0] cnt;
    logic [2:0] op;
    logic neg;
    logic [31:0] opnd;
    logic [63:0] acc, acc_nxt, prod;
    logic [32:0] rem, rem_nxt, add_sum, shifted;
    logic [33:0] diff;
    logic [31:0] quo, rmd, final_val, mag_a, mag_b;
    logic [2:0] funct3;
    logic start, last, sa, sb, neg_a, neg_b;
    logic unused_ctrl;

    assign unused_ctrl = ^{control_result[10:7], control_result[5:3]};
    assign funct3 = control_result[2:0];
    assign start = state == IDLE && valid && control_result[6] && !flush;
    assign last = state == CALC && !flush && cnt == 6'd31;
    assign ready = state == IDLE;
    assign done = state == DONE;
    assign sa = funct3[2] ? !funct3[0] : funct3[1] ^ funct3[0];
    assign sb = funct3[2] ? !funct3[0] : funct3[1:0] == 2'b01;
    assign neg_a = sa && operand_a[31];
    assign neg_b = sb && operand_b[31];
    assign mag_a = neg_a ? -operand_a : operand_a;
    assign mag_b = neg_b ? -operand_b : operand_b;
    // Multiply keeps the multiplier in acc[31:0]; divide keeps the dividend/quotient there.
    assign add_sum = {1'b0, acc[63:32]} + {1'b0, acc[0] ? opnd : 32'd0};
    assign shifted = {rem[31:0], acc[31]};
    assign diff = {1'b0, shifted} - {2'b00, opnd};
    assign acc_nxt = op[2] ? {acc[63:32], acc[30:0], !diff[33]} : {add_sum, acc[31:1]};
    assign rem_nxt = op[2] ? (diff[33] ? shifted : diff[32:0]) : rem;
    assign prod = neg ? -acc_nxt : acc_nxt;
    assign quo = neg ? -acc_nxt[31:0] : acc_nxt[31:0];
    assign rmd = neg ? -rem_nxt[31:0] : rem_nxt[31:0];
    assign final_val = !op[2] ? (op == 3'b000 ? prod[31:0] : prod[63:32]) : op[1] ? rmd : quo;

    always_comb begin
        state_next = state == IDLE ? (start ? CALC : IDLE) :
                     state == CALC ? (flush ? IDLE : cnt == 6'd31 ? DONE : CALC) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            op <= '0;
            neg <= 1'b0;
            opnd <= '0;
            acc <= '0;
            rem <= '0;
            result <= '0;
        end else if (start) begin
            cnt <= '0;
            op <= funct3;
            // A zero divisor must yield all-ones for signed DIV too, so suppress the quotient sign.
            neg <= (funct3[2] && funct3[1]) ? neg_a : (neg_a ^ neg_b) && (!funct3[2] || operand_b != 32'd0);
            opnd <= funct3[2] ? mag_b : mag_a;
            acc <= {32'd0, funct3[2] ? mag_a : mag_b};
            rem <= '0;
        end else if (state == CALC) begin
            cnt <= cnt + 6'd1;
            acc <= acc_nxt;
            rem <= rem_nxt;
            if (last) result <= final_val;
        end
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Valid  input  1  upstream issue strobe for the current instruction.
REQ-004 ControlResult  input  11  ALU control word: bit 6 = mul/div select; bits 2:0 = Funct3 operation code.
REQ-005 OperandA  input  32  rs1 value (multiplicand / dividend).
REQ-006 OperandB  input  32  rs2 value (multiplier / divisor).
REQ-007 Flush  input  1  pipeline kill; aborts any operation in progress.
REQ-008 Ready  output  1  high only in IDLE; unit can accept a new operation.
REQ-009 Done  output  1  one-cycle pulse; Result is valid this cycle.
REQ-010 Result  output  32  final result; holds its value until the next Done.

Function
REQ-011 The unit SHALL implement three states: IDLE, CALC and DONE.
REQ-012 A start SHALL occur when the state is IDLE, Valid=1, ControlResult[6]=1 and Flush=0; operands and Funct3 are latched that cycle (cycle t).
REQ-013 Valid SHALL be ignored in CALC and DONE, and also when ControlResult[6]=0.
REQ-014 Funct3 decoding SHALL be:
  - 000 MUL: low 32 bits of the product
  - 001 MULH: high 32 bits, signed x signed
  - 010 MULHSU: high 32 bits, signed A x unsigned B
  - 011 MULHU: high 32 bits, unsigned x unsigned
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-015 Signed operands SHALL be converted to magnitudes at start, and the result sign SHALL be applied when leaving CALC:
  - product sign = XOR of the operand signs
  - quotient sign = XOR of the operand signs
  - remainder sign = dividend sign
REQ-016 Multiply SHALL be radix-2 shift-add into a 64-bit accumulator; divide SHALL be radix-2 restoring into a 32-bit quotient and a 33-bit partial remainder.
REQ-017 A 6-bit iteration counter SHALL run 32 iterations, one per cycle, in CALC during cycles t+1..t+32.
REQ-018 The state SHALL go CALC->DONE after the 32nd iteration and DONE->IDLE unconditionally.
REQ-019 Latency SHALL be fixed: Done=1 in cycle t+33, and Ready returns high in cycle t+34, for every operation including the special cases.
REQ-020 Divide by zero SHALL give:
  - DIV/DIVU: 0xFFFFFFFF
  - REM/REMU: OperandA
REQ-021 Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF) SHALL give DIV=0x80000000 and REM=0x00000000.
REQ-022 Flush=1 in CALC SHALL force IDLE on the next edge, with no Done pulse and Result unchanged.
REQ-023 Flush=1 in IDLE SHALL block a start in the same cycle.
REQ-024 Flush=1 in DONE SHALL have no effect: Done still pulses and the state goes to IDLE.
REQ-025 Result SHALL update only on the edge entering DONE.
REQ-026 Done SHALL never be high for two consecutive cycles.

Reset
REQ-027 Reset=1 SHALL immediately, without waiting for a clock edge, force:
  - state = IDLE, counter = 0
  - Ready = 1, Done = 0
  - Result = 0x00000000
  - accumulators = 0
REQ-028 Reset mid-operation SHALL discard the operation with no Done pulse; the first start after Reset deasserts SHALL behave per REQ-012..REQ-019.

Verification
REQ-029 Multiply cases, each started in cycle t, with Done=1 only in cycle t+33:
  - MUL A=7, B=0xFFFFFFFD -> 0xFFFFFFEB
  - MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE
  - MULH A=B=0x80000000 -> 0x40000000
  - MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF
REQ-030 Divide cases, Done in cycle t+33:
  - DIV A=0xFFFFFFF9, B=2 -> 0xFFFFFFFD
  - REM A=0xFFFFFFF9, B=2 -> 0xFFFFFFFF
  - DIVU A=100, B=7 -> 14
  - REMU A=100, B=7 -> 2
REQ-031 Special cases, Done still in cycle t+33:
  - DIVU 5/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 5
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000
  - REM of the same operands -> 0
REQ-032 Flush in cycle t+10 -> Ready=1 in t+11, no Done through t+40, Result keeps its previous value.
REQ-033 Valid held high during an operation -> exactly one Done per accepted start; back-to-back starts are separated by 34 cycles.
REQ-034 Reset pulse asserted between clock edges in cycle t+20 -> outputs immediately Ready=1, Done=0, Result=0, with no Done afterwards.
